hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage RISC-V pipeline.
- Watches the decode (D), execute (E), memory (M) and writeback (W) stages and decides four things:
  - freezing PC and IF/ID;
  - bubbling the ID/EX and EX/MEM pipeline registers;
  - flushing wrong-path instructions;
  - selecting ALU operand forwarding.
- Sequences load-use stalls and multi-cycle execute ops through a small FSM.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7).
- MC_TIMEOUT, 64, max cycles in MCWAIT before mc_timeout is raised (>=2).
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- d_rs1, d_rs2  in  5 each  source register indices of the instruction in D
- d_use_rs1, d_use_rs2  in  1 each  the D instruction actually reads rs1/rs2
- e_rd  in  5  destination of the instruction in E
- e_regwrite, e_is_load  in  1 each  E instruction writes a register / is a load
- e_branch_taken  in  1  branch or jump resolved taken in E
- e_mc_start  in  1  E holds a multi-cycle op (mul/div), pulse in its first E cycle
- mc_done  in  1  multi-cycle unit result valid
- e_rs1, e_rs2  in  5 each  source indices of the instruction in E
- m_rd, m_regwrite  in  5/1  EX/MEM destination and write enable
- w_rd, w_regwrite  in  5/1  MEM/WB destination and write enable
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID
- stall_ex  out  1  hold ID/EX
- bubble_ex  out  1  load NOP into ID/EX at next edge
- bubble_mem  out  1  load NOP into EX/MEM at next edge
- flush_id  out  1  zero IF/ID at next edge
- fwd_a_sel, fwd_b_sel  out  2 each  00 regfile, 01 from M, 10 from W
- mc_timeout  out  1  sticky error flag
- state_o  out  2  current FSM state
- stall_count  out  CNT_W  cycles with stall_if asserted

Behaviour:
- Reset (asynchronous) drives all of the following:
  - state = RUN, counters = 0, mc_timeout = 0;
  - all control outputs 0 (they decode from state = RUN with inputs ignored while reset is high).
- Reset mid-stall or mid-MCWAIT aborts to RUN immediately.
- FSM states: RUN=00, LDSTALL=01, MCWAIT=10.
- All control outputs are combinational from state and inputs. They take effect at the next clk edge in the pipeline registers.

Hazard definitions:
- load_use = e_is_load & e_regwrite & e_rd!=0 & ((d_use_rs1 & d_rs1==e_rd) | (d_use_rs2 & d_rs2==e_rd)).

RUN state, priority order:
- (1) e_mc_start:
  - assert stall_if, stall_id, stall_ex, bubble_mem;
  - go MCWAIT; mc timer = 1.
  - A taken branch paired with an mc op cannot occur; if both are high, e_mc_start wins.
- (2) e_branch_taken:
  - assert flush_id and bubble_ex for exactly this cycle;
  - no stall; stay RUN;
  - any load_use in the same cycle is ignored (D is wrong-path).
- (3) load_use:
  - assert stall_if, stall_id, bubble_ex;
  - if LOAD_STALL_CYCLES>1, go LDSTALL with remaining = LOAD_STALL_CYCLES-1; else stay RUN.
- (4) Otherwise all stall/flush outputs are 0.

LDSTALL state:
- Assert stall_if, stall_id, bubble_ex every cycle.
- Decrement remaining; at remaining==1, return to RUN on the next edge.
- Branch is ignored here: E holds a bubble.

MCWAIT state:
- Assert stall_if, stall_id, stall_ex, bubble_mem while mc_done=0; increment the timer.
- mc_done=1: deassert all stalls that cycle (E result advances); go RUN.
- Timer reaching MC_TIMEOUT without mc_done:
  - set mc_timeout (sticky until reset);
  - go RUN;
  - stalls drop.

Forwarding (combinational, all states), shown for operand A with e_rs1; operand B identical with e_rs2:
- 01 if m_regwrite & m_rd!=0 & m_rd==e_rs1;
- else 10 if w_regwrite & w_rd!=0 & w_rd==e_rs1;
- else 00.
- M has priority over W. x0 is never forwarded.

stall_count:
- +1 on every edge where stall_if=1.
- Wraps modulo 2^CNT_W.

Optional Feature:
- HAZARD_PERF_CNT_EN
  - Defined: the stall_count register and its increment logic are built as above.
  - Undefined: stall_count is tied to 0 and no counter flops exist; all other behaviour is unchanged.

Test Plan:
- Forwarding precedence:
  - Stimulus: e_rs1=5, m_rd=5/m_regwrite=1, w_rd=5/w_regwrite=1, e_rs2=6, w_rd match absent.
  - Response: fwd_a_sel=01, fwd_b_sel=00. Changing m_rd=0 gives fwd_a_sel=10.
- Load-use, LOAD_STALL_CYCLES=2:
  - Stimulus: e_is_load=1, e_regwrite=1, e_rd=3, d_rs2=3, d_use_rs2=1.
  - Response: stall_if/stall_id/bubble_ex high for exactly 2 cycles, state 00->01->00, stall_count +2.
  - Repeat with e_rd=0: no stall.
- Branch vs load-use:
  - Stimulus: e_branch_taken=1 and load_use true in the same cycle.
  - Response: flush_id=1, bubble_ex=1 for 1 cycle, stall_if=0, state stays 00.
- Multi-cycle op:
  - Stimulus: e_mc_start pulse; mc_done asserted 5 cycles later.
  - Response: stall_ex and bubble_mem high for 5 cycles, all low in the mc_done cycle, state 10->00, mc_timeout=0.
- Timeout and reset:
  - Stimulus: MC_TIMEOUT=8, e_mc_start, never mc_done.
  - Response: mc_timeout rises after 8 cycles, state returns to 00, flag stays set.
  - Then assert reset mid-way through a second MCWAIT: state 00, mc_timeout 0, stall_count 0 immediately (asynchronous).

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and ALU-forwarding control for the 5-stage RISC-V pipeline.
// Define HAZARD_PERF_CNT_EN to build the stall_count performance counter; otherwise it reads 0.
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MC_TIMEOUT        = 64,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_use_rs1,
    input  logic             d_use_rs2,
    input  logic [4:0]       e_rd,
    input  logic             e_regwrite,
    input  logic             e_is_load,
    input  logic             e_branch_taken,
    input  logic             e_mc_start,
    input  logic             mc_done,
    input  logic [4:0]       e_rs1,
    input  logic [4:0]       e_rs2,
    input  logic [4:0]       m_rd,
    input  logic             m_regwrite,
    input  logic [4:0]       w_rd,
    input  logic             w_regwrite,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             bubble_mem,
    output logic             flush_id,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mc_timeout,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned TMR_W = $clog2(MC_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        MCWAIT  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout_q, timeout_d;
    logic             load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (m_regwrite && m_rd != 5'd0 && m_rd == rs)
            return 2'b01;
        else if (w_regwrite && w_rd != 5'd0 && w_rd == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign load_use = e_is_load && e_regwrite && e_rd != 5'd0 &&
                      ((d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RUN;
            rem_q     <= '0;
            tmr_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            tmr_q     <= tmr_d;
            timeout_q <= timeout_d;
        end
    end

    // Inputs are masked while reset is high so every control output reads as idle RUN.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        tmr_d      = tmr_q;
        timeout_d  = timeout_q;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        flush_id   = 1'b0;
        fwd_a_sel  = 2'b00;
        fwd_b_sel  = 2'b00;
        if (!reset) begin
            fwd_a_sel = fwd_sel(e_rs1);
            fwd_b_sel = fwd_sel(e_rs2);
            unique case (state_q)
                RUN: begin
                    if (e_mc_start) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                        state_d    = MCWAIT;
                        tmr_d      = TMR_W'(1);
                    end else if (e_branch_taken) begin
                        flush_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (load_use) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LDSTALL;
                            rem_d   = 3'(LOAD_STALL_CYCLES - 1);
                        end
                    end
                end
                LDSTALL: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                    if (rem_q == 3'd1)
                        state_d = RUN;
                    else
                        rem_d = rem_q - 3'd1;
                end
                MCWAIT: begin
                    if (mc_done) begin
                        state_d = RUN;
                    end else if (tmr_q == TMR_W'(MC_TIMEOUT)) begin
                        timeout_d = 1'b1;
                        state_d   = RUN;
                    end else begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                        tmr_d      = tmr_q + TMR_W'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign state_o    = state_q;
    assign mc_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stall_if)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed test-plan scenarios plus randomized
// traffic compared each cycle against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int unsigned LSC   = 2;
    localparam int unsigned MCT   = 8;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       d_rs1, d_rs2, e_rd, e_rs1, e_rs2, m_rd, w_rd;
    logic             d_use_rs1, d_use_rs2, e_regwrite, e_is_load, e_branch_taken;
    logic             e_mc_start, mc_done, m_regwrite, w_regwrite;
    logic             stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_id;
    logic [1:0]       fwd_a_sel, fwd_b_sel, state_o;
    logic             mc_timeout;
    logic [CNT_W-1:0] stall_count;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // Model state: owed load-stall cycles, multi-cycle wait progress, sticky flag, stall tally.
    int unsigned m_ld_left = 0;
    bit          m_mc_on   = 1'b0;
    int unsigned m_mc_age  = 0;
    bit          m_flag    = 1'b0;
    int unsigned m_cnt     = 0;

    hazard_ctrl #(
        .LOAD_STALL_CYCLES(LSC),
        .MC_TIMEOUT(MCT),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use_rs1(d_use_rs1), .d_use_rs2(d_use_rs2),
        .e_rd(e_rd), .e_regwrite(e_regwrite), .e_is_load(e_is_load),
        .e_branch_taken(e_branch_taken), .e_mc_start(e_mc_start), .mc_done(mc_done),
        .e_rs1(e_rs1), .e_rs2(e_rs2), .m_rd(m_rd), .m_regwrite(m_regwrite),
        .w_rd(w_rd), .w_regwrite(w_regwrite),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
        .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .flush_id(flush_id),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mc_timeout(mc_timeout),
        .state_o(state_o), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (m_regwrite && m_rd != 0 && m_rd == rs) return 2'b01;
        if (w_regwrite && w_rd != 0 && w_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_ref();
`ifdef HAZARD_PERF_CNT_EN
        return CNT_W'(m_cnt);
`else
        return '0;
`endif
    endfunction

    task automatic idle();
        {d_rs1, d_rs2, e_rd, e_rs1, e_rs2, m_rd, w_rd} = '0;
        {d_use_rs1, d_use_rs2, e_regwrite, e_is_load, e_branch_taken} = '0;
        {e_mc_start, mc_done, m_regwrite, w_regwrite} = '0;
    endtask

    task automatic rand_inputs();
        d_rs1 = 5'($urandom_range(0, 3));
        d_rs2 = 5'($urandom_range(0, 3));
        e_rd  = 5'($urandom_range(0, 3));
        e_rs1 = 5'($urandom_range(0, 3));
        e_rs2 = 5'($urandom_range(0, 3));
        m_rd  = 5'($urandom_range(0, 3));
        w_rd  = 5'($urandom_range(0, 3));
        d_use_rs1      = 1'($urandom_range(0, 1));
        d_use_rs2      = 1'($urandom_range(0, 1));
        e_regwrite     = ($urandom_range(0, 3) != 0);
        e_is_load      = ($urandom_range(0, 2) == 0);
        e_branch_taken = ($urandom_range(0, 7) == 0);
        e_mc_start     = ($urandom_range(0, 15) == 0);
        mc_done        = ($urandom_range(0, 5) == 0);
        m_regwrite     = 1'($urandom_range(0, 1));
        w_regwrite     = 1'($urandom_range(0, 1));
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        logic [5:0] e_ctl; // {stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_id}
        logic [1:0] e_fa, e_fb, e_st;
        bit         lu;
        @(negedge clk);
        e_ctl = '0;
        e_fa  = 2'b00;
        e_fb  = 2'b00;
        if (reset) begin
            m_ld_left = 0; m_mc_on = 1'b0; m_mc_age = 0; m_flag = 1'b0; m_cnt = 0;
            check("state", 32'(state_o), 32'd0);
            check("flag", 32'(mc_timeout), 32'd0);
            check("count", 32'(stall_count), 32'd0);
        end else begin
            e_st = m_mc_on ? 2'd2 : (m_ld_left > 0 ? 2'd1 : 2'd0);
            check("state", 32'(state_o), 32'(e_st));
            check("flag", 32'(mc_timeout), 32'(m_flag));
            check("count", 32'(stall_count), 32'(cnt_ref()));
            e_fa = fwd_ref(e_rs1);
            e_fb = fwd_ref(e_rs2);
            lu = e_is_load && e_regwrite && e_rd != 0 &&
                 ((d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd));
            if (m_mc_on) begin
                if (mc_done) begin
                    m_mc_on = 1'b0;
                end else if (m_mc_age == MCT) begin
                    m_mc_on = 1'b0;
                    m_flag  = 1'b1;
                end else begin
                    e_ctl = 6'b111010;
                    m_mc_age++;
                end
            end else if (m_ld_left > 0) begin
                e_ctl = 6'b110100;
                m_ld_left--;
            end else if (e_mc_start) begin
                e_ctl    = 6'b111010;
                m_mc_on  = 1'b1;
                m_mc_age = 1;
            end else if (e_branch_taken) begin
                e_ctl = 6'b000101;
            end else if (lu) begin
                e_ctl     = 6'b110100;
                m_ld_left = LSC - 1;
            end
            if (e_ctl[5]) m_cnt++;
        end
        check("ctl", 32'({stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_id}), 32'(e_ctl));
        check("fwd_a", 32'(fwd_a_sel), 32'(e_fa));
        check("fwd_b", 32'(fwd_b_sel), 32'(e_fb));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [CNT_W-1:0] cnt0;
        reset = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        // Forwarding precedence: M beats W, x0 never forwarded.
        e_rs1 = 5'd5; m_rd = 5'd5; m_regwrite = 1'b1; w_rd = 5'd5; w_regwrite = 1'b1; e_rs2 = 5'd6;
        #1;
        check("fwd_a_m_prio", 32'(fwd_a_sel), 32'd1);
        check("fwd_b_none", 32'(fwd_b_sel), 32'd0);
        cycle();
        m_rd = 5'd0;
        #1;
        check("fwd_a_w", 32'(fwd_a_sel), 32'd2);
        cycle();

        // Load-use with two bubbles, then with e_rd = x0.
        idle();
        cnt0 = stall_count;
        e_is_load = 1'b1; e_regwrite = 1'b1; e_rd = 5'd3; d_rs2 = 5'd3; d_use_rs2 = 1'b1;
        cycle();
        idle();
        cycle();
        cycle();
`ifdef HAZARD_PERF_CNT_EN
        check("ld_count_delta", 32'(CNT_W'(stall_count - cnt0)), 32'd2);
`else
        check("ld_count_zero", 32'(stall_count), 32'd0);
`endif
        e_is_load = 1'b1; e_regwrite = 1'b1; e_rd = 5'd0; d_rs2 = 5'd0; d_use_rs2 = 1'b1;
        cycle();

        // Taken branch overrides a simultaneous load-use.
        e_rd = 5'd3; d_rs2 = 5'd3; e_branch_taken = 1'b1;
        cycle();
        idle();
        cycle();

        // Multi-cycle op completing after five stall cycles.
        e_mc_start = 1'b1;
        cycle();
        idle();
        for (int i = 0; i < 4; i++) cycle();
        mc_done = 1'b1;
        cycle();
        idle();
        cycle();

        // Multi-cycle op that never completes.
        e_mc_start = 1'b1;
        cycle();
        idle();
        for (int i = 0; i < 10; i++) cycle();
        check("timeout_set", 32'(mc_timeout), 32'd1);
        check("timeout_state", 32'(state_o), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
        end

        // Asynchronous reset in the middle of a second wait.
        idle();
        e_mc_start = 1'b1;
        cycle();
        idle();
        cycle();
        cycle();
        check("mcwait_before_rst", 32'(state_o), 32'd2);
        check("flag_before_rst", 32'(mc_timeout), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_state", 32'(state_o), 32'd0);
        check("async_flag", 32'(mc_timeout), 32'd0);
        check("async_count", 32'(stall_count), 32'd0);
        check("async_stall", 32'({stall_if, stall_ex, bubble_mem}), 32'd0);
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
